sram_bist_ctrl: RTL and testbench
=================================

SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, address width of the target SRAM BIST port.
REQ-002 SHALL have parameter DATA_W, default 32, data/bit-mask width of the target SRAM BIST port.
REQ-003 SHALL have parameter DEPTH, default 512, number of words tested (addresses 0..DEPTH-1, DEPTH <= 2^ADDR_W, DEPTH >= 2).
REQ-004 clk  input  1  single clock; also drives the SRAM BIST clock externally.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request a March C- run; sampled only in IDLE.
REQ-007 busy  output  1  high from first test cycle until done.
REQ-008 done  output  1  one-cycle pulse at end of run (pass or abort).
REQ-009 pass  output  1  result of last run; valid from done onward, held until next start.
REQ-010 fail_addr  output  ADDR_W  address of first mismatch.
REQ-011 fail_elem  output  3  March element (1..5) of first mismatch.
REQ-012 bist_en, bist_men, bist_wen, bist_ren  output  1 each  SRAM BIST enable, macro enable, write strobe, read strobe.
REQ-013 bist_addr  output  ADDR_W  SRAM BIST address.
REQ-014 bist_din, bist_bm  output  DATA_W  SRAM BIST write data and bit mask.
REQ-015 bist_dout  input  DATA_W  SRAM read data, valid the cycle after a bist_ren cycle.

Function
REQ-016 SHALL run March C- on the array: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-017 SHALL use FSM states IDLE, M0..M5, TAIL, DONE; IDLE->M0 on start; Mk->Mk+1 after last address of Mk; M5->TAIL; TAIL->DONE; DONE->IDLE unconditionally after one cycle.
REQ-018 M0: one write per cycle, addresses 0..DEPTH-1, DEPTH cycles.
REQ-019 M1..M4: two cycles per address: cycle A read (bist_ren=1); cycle B compare bist_dout to expected and write (bist_wen=1) same address; 2*DEPTH cycles per element.
REQ-020 M5: one read per cycle, addresses ascending; each read compared one cycle later (pipelined); TAIL compares the last read.
REQ-021 Up elements SHALL count 0..DEPTH-1, down elements DEPTH-1..0; no address outside 0..DEPTH-1 SHALL ever be driven while busy.
REQ-022 During any test cycle bist_en=1, bist_men=1, bist_bm all-ones; bist_wen and bist_ren never high in the same cycle.
REQ-023 In IDLE and DONE, all bist_* outputs SHALL be 0.
REQ-024 Fault-free run: start sampled at edge 0 -> first write at cycle 1; done=1 during cycle 6*DEPTH+2 (5122 for DEPTH=512), pass=1.
REQ-025 On first mismatch SHALL capture fail_addr and fail_elem, set pass=0, suppress that cycle's write, and go to DONE next cycle (abort).
REQ-026 start while busy or in DONE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new run.
REQ-027 New run SHALL clear pass, fail_addr, fail_elem at the start-sampling edge.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, pass=0, fail_addr=0, fail_elem=0, all bist_* = 0, including mid-run; no SRAM access in the cycle following the reset edge.

Verification
REQ-029 Fault-free SRAM model, DEPTH=512, pulse start -> busy for 5121 cycles, done at cycle 5122, pass=1, bist_* zero afterwards.
REQ-030 Model with bit 5 of address 0x1A7 stuck-at-1 -> fail at M1 read of 0x1A7: fail_elem=1, fail_addr=0x1A7, pass=0, done one cycle later, no write to 0x1A7 in M1.
REQ-031 Model with address 0x000 stuck-at-0 in bit 0 (writes of 1 lost) -> fail_elem=2, fail_addr=0x000.
REQ-032 Coupling fault: write of 1 to 0x100 flips 0x0FF to 1 -> detected in M3 (down r0) at 0x0FF: fail_elem=3, fail_addr=0x0FF.
REQ-033 Deassert rst_n in the middle of M2 -> next cycle busy=0, bist_en=0, pass=0; subsequent start gives a full fault-free run with pass=1.
REQ-034 Assert start continuously through a run -> exactly one run per IDLE visit, second run begins the cycle after DONE, done pulses are each one cycle wide.

Source files
------------

// File: rtl/sram_bist_if.sv
// SRAM BIST port bundle between the March C- controller and the memory macro.
interface sram_bist_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              bist_en;
  logic              bist_men;
  logic              bist_wen;
  logic              bist_ren;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din;
  logic [DATA_W-1:0] bist_bm;
  logic [DATA_W-1:0] bist_dout;

  modport master (
    output bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    input  bist_dout
  );

  modport slave (
    input  bist_en, bist_men, bist_wen, bist_ren, bist_addr, bist_din, bist_bm,
    output bist_dout
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM; aborts on the first mismatch
// and reports the failing address and March element.
//
// state | meaning
// IDLE  | waiting for start, SRAM port quiet
// M0    | up(w0), one write per cycle
// M1    | up(r0,w1), read cycle then compare+write cycle per address
// M2    | up(r1,w0)
// M3    | down(r0,w1)
// M4    | down(r1,w0)
// M5    | up(r0), pipelined: each cycle reads one address, checks the previous
// TAIL  | checks the final M5 read
// DONE  | one-cycle done pulse, result visible
module sram_bist_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  sram_bist_if.master       bist
);

  typedef enum logic [3:0] {
    IDLE, M0, M1, M2, M3, M4, M5, TAIL, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              phase, phase_nxt;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;

  logic              up;
  logic [2:0]        elem;
  logic [DATA_W-1:0] rd_exp;
  logic [DATA_W-1:0] wr_data;
  state_t            elem_next;
  logic [ADDR_W-1:0] elem_next_addr;
  logic              at_last;
  logic [ADDR_W-1:0] addr_step;

  logic              test;
  logic              wen;
  logic              ren;
  logic              mismatch;
  logic [ADDR_W-1:0] cmp_addr;

  // Per-element direction, data polarity and successor.
  always_comb begin
    up             = 1'b1;
    elem           = 3'd0;
    rd_exp         = '0;
    wr_data        = '0;
    elem_next      = IDLE;
    elem_next_addr = '0;
    case (state)
      M0: begin
        elem_next = M1;
      end
      M1: begin
        elem      = 3'd1;
        wr_data   = '1;
        elem_next = M2;
      end
      M2: begin
        elem           = 3'd2;
        rd_exp         = '1;
        elem_next      = M3;
        elem_next_addr = LAST_ADDR;
      end
      M3: begin
        up             = 1'b0;
        elem           = 3'd3;
        wr_data        = '1;
        elem_next      = M4;
        elem_next_addr = LAST_ADDR;
      end
      M4: begin
        up        = 1'b0;
        elem      = 3'd4;
        rd_exp    = '1;
        elem_next = M5;
      end
      M5, TAIL: begin
        elem      = 3'd5;
        elem_next = TAIL;
      end
      default: ;
    endcase
  end

  assign at_last   = up ? (addr == LAST_ADDR) : (addr == '0);
  assign addr_step = up ? (addr + 1'b1) : (addr - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    phase_nxt = phase;
    test      = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    mismatch  = 1'b0;
    cmp_addr  = addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = M0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
        end
      end
      M0: begin
        test = 1'b1;
        wen  = 1'b1;
        if (at_last) begin
          state_nxt = elem_next;
          addr_nxt  = elem_next_addr;
        end else begin
          addr_nxt = addr_step;
        end
      end
      M1, M2, M3, M4: begin
        test = 1'b1;
        if (!phase) begin
          ren       = 1'b1;
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          mismatch  = (bist.bist_dout != rd_exp);
          // a failing cell is left untouched so it can be inspected afterwards
          wen       = !mismatch;
          if (mismatch) begin
            state_nxt = DONE;
          end else if (at_last) begin
            state_nxt = elem_next;
            addr_nxt  = elem_next_addr;
          end else begin
            addr_nxt = addr_step;
          end
        end
      end
      M5: begin
        test     = 1'b1;
        ren      = 1'b1;
        cmp_addr = rd_addr;
        mismatch = rd_pend && (bist.bist_dout != rd_exp);
        if (mismatch)     state_nxt = DONE;
        else if (at_last) state_nxt = TAIL;
        else              addr_nxt  = addr_step;
      end
      TAIL: begin
        test      = 1'b1;
        cmp_addr  = rd_addr;
        mismatch  = (bist.bist_dout != rd_exp);
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      phase     <= 1'b0;
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      addr    <= addr_nxt;
      phase   <= phase_nxt;
      rd_pend <= (state == M5);
      rd_addr <= addr;
      if (state == IDLE && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end
      if (mismatch) begin
        fail_addr <= cmp_addr;
        fail_elem <= elem;
      end else if (state == TAIL) begin
        pass <= 1'b1;
      end
    end
  end

  assign busy = test;
  assign done = (state == DONE);

  assign bist.bist_en   = test;
  assign bist.bist_men  = test;
  assign bist.bist_wen  = wen;
  assign bist.bist_ren  = ren;
  assign bist.bist_addr = test ? addr : '0;
  assign bist.bist_din  = test ? wr_data : '0;
  assign bist.bist_bm   = test ? '1 : '0;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: behavioural SRAM with injectable faults,
// a table of full runs, and hand-written reset / back-to-back start sequences.
module tb_sram_bist_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  sram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .bist      (bus)
  );

  always #5 clk = ~clk;

  // fault: 0 none, 1 bit5 of 0x1A7 stuck-at-1, 2 bit0 of 0x000 stuck-at-0,
  // 3 writing ones to 0x100 forces 0x0FF to ones
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q = '0;
  int                fault = 0;
  int                wr1a7_ones = 0;
  int                prot_err = 0;

  assign bus.bist_dout = rd_q;

  always @(posedge clk) begin
    if (bus.bist_en && bus.bist_men) begin
      if (bus.bist_wen) begin
        if (fault == 2 && bus.bist_addr == 9'h000)
          mem[bus.bist_addr] <= bus.bist_din & ~32'h1;
        else
          mem[bus.bist_addr] <= bus.bist_din;
        if (fault == 3 && bus.bist_addr == 9'h100 && bus.bist_din == '1)
          mem[9'h0FF] <= '1;
        if (bus.bist_addr == 9'h1A7 && bus.bist_din == '1)
          wr1a7_ones <= wr1a7_ones + 1;
      end
      if (bus.bist_ren)
        rd_q <= mem[bus.bist_addr] |
                ((fault == 1 && bus.bist_addr == 9'h1A7) ? 32'h20 : 32'h0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bist_wen && bus.bist_ren)
        prot_err <= prot_err + 1;
      else if (busy && (!bus.bist_en || !bus.bist_men || bus.bist_bm != '1))
        prot_err <= prot_err + 1;
      else if (!busy && (bus.bist_en || bus.bist_men || bus.bist_wen || bus.bist_ren ||
                         bus.bist_addr != '0 || bus.bist_din != '0 || bus.bist_bm != '0))
        prot_err <= prot_err + 1;
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_once(output int done_cyc, output int busy_cyc);
    int n;
    done_cyc = -1;
    busy_cyc = 0;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n < 6000) begin
      @(negedge clk);
      n++;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  typedef struct {
    int              fault;
    logic            exp_pass;
    logic [2:0]      exp_elem;
    logic [ADDR_W-1:0] exp_addr;
    int              exp_done;
    int              exp_w1a7;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   dcyc, bcyc, w0, n, pulses, first, second, wide;
    logic prev_done;

    vecs[0] = '{1, 1'b0, 3'd1, 9'h1A7, 1361, 0};
    vecs[1] = '{0, 1'b1, 3'd0, 9'h000, 5122, 2};
    vecs[2] = '{2, 1'b0, 3'd2, 9'h000, 1539, 1};
    vecs[3] = '{3, 1'b0, 3'd3, 9'h0FF, 3075, 2};
    vecs[4] = '{0, 1'b1, 3'd0, 9'h000, 5122, 2};

    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0);
    chk("rst_bist_en", bus.bist_en, 0);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      fault = vecs[i].fault;
      w0 = wr1a7_ones;
      run_once(dcyc, bcyc);
      chk($sformatf("run%0d_done_cycle", i), dcyc, vecs[i].exp_done);
      chk($sformatf("run%0d_busy_cycles", i), bcyc, vecs[i].exp_done - 1);
      chk($sformatf("run%0d_pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("run%0d_fail_elem", i), fail_elem, vecs[i].exp_elem);
      chk($sformatf("run%0d_fail_addr", i), fail_addr, vecs[i].exp_addr);
      @(negedge clk);
      chk($sformatf("run%0d_ones_writes_1a7", i), wr1a7_ones - w0, vecs[i].exp_w1a7);
      chk($sformatf("run%0d_done_width", i), done, 0);
      chk($sformatf("run%0d_idle_bist_en", i), bus.bist_en, 0);
      chk($sformatf("run%0d_pass_held", i), pass, vecs[i].exp_pass);
    end

    // reset in the middle of M2 (cycles 1537..2560)
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (1600) @(negedge clk);
    chk("m2_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_bist_en", bus.bist_en, 0);
    chk("midrst_strobes", {bus.bist_wen, bus.bist_ren}, 0);
    chk("midrst_pass", pass, 0);
    rst_n = 1'b1;
    run_once(dcyc, bcyc);
    chk("postrst_done_cycle", dcyc, 5122);
    chk("postrst_pass", pass, 1);

    // start held high across two runs
    @(negedge clk);
    start = 1'b1;
    n = 0; pulses = 0; first = -1; second = -1; wide = 0;
    prev_done = 1'b0;
    @(posedge clk);
    while (n < 11000 && pulses < 2) begin
      @(negedge clk);
      n++;
      if (done && prev_done) wide++;
      if (done) begin
        pulses++;
        if (pulses == 1) first = n;
        else             second = n;
      end
      prev_done = done;
    end
    start = 1'b0;
    @(negedge clk);
    chk("cont_done_width2", done, 0);
    repeat (3) @(negedge clk);
    chk("cont_no_third_run", busy, 0);
    chk("cont_first_done", first, 5122);
    chk("cont_second_done", second, 10245);
    chk("cont_wide_pulses", wide, 0);
    chk("cont_pass", pass, 1);

    chk("protocol_violations", prot_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
